// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: builds the extended immediate and pc-relative
// target, then holds results in a two-entry skid buffer behind a valid/ready handshake.
module imm_gen_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  input  logic [PC_W-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [PC_W-1:0] out_target,
  output logic            out_illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [PC_W-1:0] target;
    logic            illegal;
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d;
  entry_t new_entry;
  logic signed [31:0] imm32;
  logic accept, pop;
  logic unused_opcode;

  assign unused_opcode = ^instr[6:0];

  // Every format fits in 32 bits with its sign in bit 31, so one signed widening covers XLEN=64
  always_comb begin
    imm32 = '0;
    new_entry.illegal = 1'b0;
    case (imm_src)
      3'b000: imm32 = {{20{instr[31]}}, instr[31:20]};
      3'b001: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      3'b100: imm32 = {instr[31:12], 12'b0};
      3'b101: imm32 = {27'b0, instr[19:15]};
      default: new_entry.illegal = 1'b1;
    endcase
    new_entry.imm    = XLEN'(imm32);
    new_entry.target = pc + PC_W'($signed(new_entry.imm));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    accept  = in_valid & in_ready;
    pop     = out_valid & out_ready;
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_d = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    in_ready    = (state_q != TWO);
    out_valid   = (state_q != EMPTY);
    out_imm     = main_q.imm;
    out_target  = main_q.target;
    out_illegal = main_q.illegal;
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: XLEN=32 instance for the handshake and formats,
// plus an XLEN=64 instance sharing the same stimulus for the U-format widening.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic [31:0] pc;
  logic [63:0] pc64;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm, out_target;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64, out_target64;

  int passed = 0;
  int total  = 0;

  assign pc64 = {32'b0, pc};

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .imm_src(imm_src), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_target(out_target), .out_illegal(out_illegal)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .imm_src(imm_src), .pc(pc64),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_target(out_target64), .out_illegal(out_illegal64)
  );

  // Inputs change at the negedge so they are stable across the following posedge
  task automatic drive(input logic [31:0] i, input logic [2:0] s, input logic [31:0] p);
    in_valid = 1'b1;
    instr    = i;
    imm_src  = s;
    pc       = p;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; imm_src = '0; pc = '0;
    step(); step();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready); else passed++;
    total++; if (out_imm !== 32'h0) $display("[TB] FAIL reset_out_imm got %h expected 0", out_imm); else passed++;
    total++; if (out_target !== 32'h0) $display("[TB] FAIL reset_out_target got %h expected 0", out_target); else passed++;
    total++; if (out_illegal !== 1'b0) $display("[TB] FAIL reset_out_illegal got %b expected 0", out_illegal); else passed++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_itype();
    drive(32'hFFF00093, 3'b000, 32'h100);
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL i_valid got %b expected 1", out_valid); else passed++;
    total++; if (out_imm !== 32'hFFFFFFFF) $display("[TB] FAIL i_imm got %h expected ffffffff", out_imm); else passed++;
    total++; if (out_target !== 32'h000000FF) $display("[TB] FAIL i_target got %h expected 000000ff", out_target); else passed++;
    total++; if (out_illegal !== 1'b0) $display("[TB] FAIL i_illegal got %b expected 0", out_illegal); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL i_drain_valid got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_branch_jump();
    drive(32'hFE000EE3, 3'b010, 32'h100);
    step();
    total++; if (out_imm !== 32'hFFFFFFFC) $display("[TB] FAIL b_imm got %h expected fffffffc", out_imm); else passed++;
    total++; if (out_target !== 32'h000000FC) $display("[TB] FAIL b_target got %h expected 000000fc", out_target); else passed++;
    drive(32'h0080006F, 3'b011, 32'h200);
    step();
    in_valid = 1'b0;
    total++; if (out_imm !== 32'h00000008) $display("[TB] FAIL j_imm got %h expected 00000008", out_imm); else passed++;
    total++; if (out_target !== 32'h00000208) $display("[TB] FAIL j_target got %h expected 00000208", out_target); else passed++;
    step();
  endtask

  task automatic test_upper_csr();
    drive(32'h123450B7, 3'b100, 32'h0);
    step();
    total++; if (out_imm !== 32'h12345000) $display("[TB] FAIL u_imm got %h expected 12345000", out_imm); else passed++;
    total++; if (out_imm64 !== 64'h0000000012345000) $display("[TB] FAIL u64_pos_imm got %h expected 0000000012345000", out_imm64); else passed++;
    drive(32'h800000B7, 3'b100, 32'h1000);
    step();
    total++; if (out_imm64 !== 64'hFFFFFFFF80000000) $display("[TB] FAIL u64_imm got %h expected ffffffff80000000", out_imm64); else passed++;
    total++; if (out_target64 !== 64'hFFFFFFFF80001000) $display("[TB] FAIL u64_target got %h expected ffffffff80001000", out_target64); else passed++;
    total++; if (out_target !== 32'h80001000) $display("[TB] FAIL u32_wrap_target got %h expected 80001000", out_target); else passed++;
    drive(32'h000FD073, 3'b101, 32'h10);
    step();
    in_valid = 1'b0;
    total++; if (out_imm !== 32'h0000001F) $display("[TB] FAIL z_imm got %h expected 0000001f", out_imm); else passed++;
    total++; if (out_target !== 32'h0000002F) $display("[TB] FAIL z_target got %h expected 0000002f", out_target); else passed++;
    total++; if (out_imm64 !== 64'h000000000000001F) $display("[TB] FAIL z64_imm got %h expected 000000000000001f", out_imm64); else passed++;
    drive(32'hFE000FA3, 3'b001, 32'h40);
    step();
    in_valid = 1'b0;
    total++; if (out_imm !== 32'hFFFFFFFF) $display("[TB] FAIL s_imm got %h expected ffffffff", out_imm); else passed++;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(32'h00100093, 3'b000, 32'h0);
    step();
    drive(32'h00200093, 3'b000, 32'h0);
    step();
    drive(32'h00300093, 3'b000, 32'h0);
    total++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_full_ready got %b expected 0", in_ready); else passed++;
    total++; if (out_imm !== 32'h1) $display("[TB] FAIL bp_head_a got %h expected 00000001", out_imm); else passed++;
    step();
    total++; if (out_imm !== 32'h1 || out_valid !== 1'b1) $display("[TB] FAIL bp_hold_a got %h/%b expected 00000001/1", out_imm, out_valid); else passed++;
    total++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_hold_ready got %b expected 0", in_ready); else passed++;
    out_ready = 1'b1;
    step();
    total++; if (out_imm !== 32'h2 || out_valid !== 1'b1) $display("[TB] FAIL bp_out_b got %h/%b expected 00000002/1", out_imm, out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready_back got %b expected 1", in_ready); else passed++;
    step();
    in_valid = 1'b0;
    total++; if (out_imm !== 32'h3 || out_valid !== 1'b1) $display("[TB] FAIL bp_out_c got %h/%b expected 00000003/1", out_imm, out_valid); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_no_dup got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive({12'(k * 16), 20'h00093}, 3'b000, 32'h0);
      step();
      total++;
      if (out_valid !== 1'b1 || out_imm !== 32'(k * 16))
        $display("[TB] FAIL b2b_%0d got %h/%b expected %h/1", k, out_imm, out_valid, 32'(k * 16));
      else passed++;
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    drive(32'hFFF00093, 3'b111, 32'h300);
    step();
    total++; if (out_imm !== 32'h0) $display("[TB] FAIL ill_imm got %h expected 0", out_imm); else passed++;
    total++; if (out_illegal !== 1'b1) $display("[TB] FAIL ill_flag got %b expected 1", out_illegal); else passed++;
    total++; if (out_target !== 32'h300) $display("[TB] FAIL ill_target got %h expected 00000300", out_target); else passed++;
    drive(32'h00500093, 3'b110, 32'h20);
    step();
    total++; if (out_illegal !== 1'b1 || out_target !== 32'h20) $display("[TB] FAIL ill110 got %b/%h expected 1/00000020", out_illegal, out_target); else passed++;
    drive(32'h00500093, 3'b000, 32'h0);
    step();
    in_valid = 1'b0;
    total++; if (out_illegal !== 1'b0 || out_imm !== 32'h5) $display("[TB] FAIL legal_after got %b/%h expected 0/00000005", out_illegal, out_imm); else passed++;
    step();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    drive(32'h07700093, 3'b000, 32'h0);
    step();
    drive(32'h08800093, 3'b000, 32'h0);
    step();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) $display("[TB] FAIL mr_full got %b expected 0", in_ready); else passed++;
    rst = 1'b0;
    step();
    rst = 1'b1;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL mr_valid got %b expected 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL mr_ready got %b expected 1", in_ready); else passed++;
    total++; if (out_imm !== 32'h0) $display("[TB] FAIL mr_imm got %h expected 0", out_imm); else passed++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (out_valid !== 1'b0) $display("[TB] FAIL mr_ghost_%0d got %b expected 0", k, out_valid); else passed++;
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; imm_src = '0; pc = '0;
    test_reset();
    test_itype();
    test_branch_jump();
    test_upper_csr();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Parametrised, pipelined immediate generator for the decode stage.
- Extracts and sign- or zero-extends the immediate for all RISC-V formats (I, S, B, J, U, CSR-uimm) to XLEN bits.
- Computes the PC-relative target pc + imm.
- Sits between fetch/decode and execute behind a valid/ready handshake, with a 2-entry skid buffer so back-pressure never drops or duplicates an instruction.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
PC_W, XLEN, width of the pc input and of the target output.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low
in_valid  in  1  upstream has an instruction
in_ready  out  1  stage can accept this cycle
instr  in  32  instruction word
imm_src  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR uimm), 110/111 illegal
pc  in  PC_W  pc of instr
out_valid  out  1  result available
out_ready  in  1  downstream accepts
out_imm  out  XLEN  extended immediate
out_target  out  PC_W  pc + out_imm, modulo 2^PC_W
out_illegal  out  1  imm_src was 110/111

Behaviour:
- One clock; reset is synchronous and active-low. rst low at a clock edge clears both buffer entries.
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_target=0, out_illegal=0.
- Reset mid-operation discards all held entries; nothing is emitted afterwards.
- Immediate formation is combinational on the inputs and registered on accept. s = instr[31].
  - I: s-ext instr[31:20]
  - S: s-ext {instr[31:25], instr[11:7]}
  - B: s-ext {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} (13 bits)
  - J: s-ext {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} (21 bits)
  - U: {instr[31:12], 12'b0}; for XLEN=64 sign-extended from bit 31
  - Z: zero-ext instr[19:15]
  - 110/111: imm=0, illegal=1; the entry still flows through the pipe.
- Target: pc + imm truncated to PC_W; computed before registering, no extra latency.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - out_* are stable while out_valid & !out_ready.
  - in_valid may drop without a transfer.
- Storage: main entry (drives outputs) and skid entry.
- in_ready = !skid_full, a registered signal with no combinational path from out_ready.
- States (derived from entry occupancy): EMPTY, ONE, TWO.
  - EMPTY: accept -> ONE.
  - ONE:
    - accept & !pop -> TWO (new data into skid)
    - accept & pop -> ONE (new data into main)
    - pop only -> EMPTY
    - neither -> ONE
  - TWO: in_ready=0.
    - pop -> ONE, skid moves to main.
    - no pop -> TWO.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput: 1 per cycle with out_ready held high.
- Ordering: strictly FIFO across both entries.

Test Plan:
1. Reset, then imm_src=000, instr=0xFFF00093, pc=0x100, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_target=0xFF, out_illegal=0.
2. imm_src=010, instr=0xFE000EE3 (beq -4), pc=0x100 -> out_imm=0xFFFFFFFC, out_target=0xFC. Then imm_src=011, instr=0x0080006F (jal +8), pc=0x200 -> out_imm=0x8, out_target=0x208.
3. imm_src=100, instr=0x123450B7 -> out_imm=0x12345000. With XLEN=64 and instr=0x800000B7 -> out_imm=0xFFFFFFFF80000000. imm_src=101, instr=0x000FD073 -> out_imm=0x1F.
4. out_ready=0, three back-to-back valid inputs A,B,C -> A and B accepted, in_ready=0 from the cycle after B, C held. Raise out_ready -> outputs A,B,C in order, no gaps, no duplicates.
5. imm_src=111, any instr -> out_imm=0, out_illegal=1, out_target=pc. A following legal input has out_illegal=0.
6. Stage holding two entries, rst low for one edge -> out_valid=0, in_ready=1 next cycle. Neither held entry ever appears on the outputs.
